// File: rtl/recip_seed_nr_ctrl.sv
// recip_seed_nr_ctrl
//   Turns an unsigned divisor into a normalized Q0.RW reciprocal for the divider
//   datapath. The divisor is left-normalized to d_norm in [1,2). A seed is fetched
//   from an external 256-entry ROM and then refined with ITER Newton-Raphson steps.
//   Both multiplies of each step share a single multiplier.
//
// Parameters: DW divisor width (>= 9), RW reciprocal fraction width, ITER NR steps (0..3)
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   in_valid/ready   divisor handshake; in_ready is high only in IDLE
//   divisor          unsigned divisor
//   rom_addr         registered seed ROM address (top fraction bits of d_norm)
//   rom_dout         seed ROM data (combinational ROM, MSB always 1)
//   out_valid/ready  result handshake; the result is held until it is accepted
//   recip            1/d_norm in Q0.RW, saturated to all ones
//   shift            index of the divisor's leading one; 1/divisor = recip * 2^-shift
//   div_by_zero      divisor was 0
// Optional build macro RECIP_SEED_NR_STATS_EN adds two outputs:
//   op_count         accepted results, wrapping 16-bit count
//   busy_cycles      cycles spent outside IDLE, saturating 32-bit count
//
// state | meaning
// IDLE  | waiting for a divisor
// NORM  | normalize the divisor, record the shift, issue the ROM address
// SEED  | load the seed from the ROM as the first estimate
// MUL_A | p = d_norm * x, e = 2 - p
// MUL_B | x = x * e (saturating), count the iteration
// DONE  | result presented until it is accepted
module recip_seed_nr_ctrl #(
  parameter int DW   = 16,
  parameter int RW   = 16,
  parameter int ITER = 2,
  localparam int SW  = $clog2(DW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] divisor,
  output logic [7:0]    rom_addr,
  input  logic [7:0]    rom_dout,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] recip,
  output logic [SW-1:0] shift,
  output logic          div_by_zero
`ifdef RECIP_SEED_NR_STATS_EN
  ,
  output logic [15:0]   op_count,
  output logic [31:0]   busy_cycles
`endif
);

  localparam int MW = ((DW > RW) ? DW : RW) + 2;
  localparam int LO = ((DW - 1) < RW) ? (DW - 1) : RW;

  typedef enum logic [2:0] {IDLE, NORM, SEED, MUL_A, MUL_B, DONE} state_t;

  state_t          state_q, state_n;
  logic [DW-1:0]   d_q;
  logic [RW-1:0]   x_q;
  logic [RW+1:0]   e_q;
  logic [1:0]      iter_q;
  logic [SW-1:0]   shift_q;
  logic            dbz_q;
  logic [7:0]      rom_addr_q;

  logic [SW-1:0]   lead;
  logic [SW-1:0]   norm_amt;
  logic [DW-1:0]   d_norm;
  logic [MW-1:0]   mul_a, mul_b;
  logic [2*MW-1:0] prod;
  logic [RW:0]     p;
  logic [RW+1:0]   e_next;
  logic [RW-1:0]   x_next;
  logic            unused_prod_bits;

  function automatic logic [SW-1:0] lead_one(input logic [DW-1:0] v);
    lead_one = '0;
    for (int i = 0; i < DW; i++)
      if (v[i]) lead_one = i[SW-1:0];
  endfunction

  assign lead     = lead_one(d_q);
  assign norm_amt = SW'(DW - 1) - lead;
  assign d_norm   = d_q << norm_amt;

  // The one multiplier: MUL_A forms d_norm*x, MUL_B forms x*e.
  always_comb begin
    mul_a = MW'(d_q);
    mul_b = MW'(x_q);
    if (state_q == MUL_B) begin
      mul_a = MW'(x_q);
      mul_b = MW'(e_q);
    end
  end

  assign prod   = mul_a * mul_b;
  // Q1.(DW-1) * Q0.RW, keep Q1.RW
  assign p      = prod[DW-1+RW -: RW+1];
  assign e_next = {2'b10, {RW{1'b0}}} - {1'b0, p};
  // Q0.RW * Q2.RW, keep Q0.RW; anything at or above 1.0 clamps to all ones
  assign x_next = (|prod[2*MW-1:2*RW]) ? '1 : prod[2*RW-1:RW];
  assign unused_prod_bits = ^prod[LO-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  always_comb begin
    state_n   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid) state_n = (divisor == '0) ? DONE : NORM;
      end
      NORM:  state_n = SEED;
      SEED:  state_n = (ITER > 0) ? MUL_A : DONE;
      MUL_A: state_n = MUL_B;
      MUL_B: state_n = (iter_q == 2'(ITER - 1)) ? DONE : MUL_A;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q        <= '0;
      x_q        <= '0;
      e_q        <= '0;
      iter_q     <= '0;
      shift_q    <= '0;
      dbz_q      <= 1'b0;
      rom_addr_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          d_q   <= divisor;
          dbz_q <= (divisor == '0);
          // A zero divisor goes straight to DONE with a saturated result.
          if (divisor == '0) begin
            x_q     <= '1;
            shift_q <= '0;
          end
        end
        NORM: begin
          d_q        <= d_norm;
          shift_q    <= lead;
          rom_addr_q <= d_norm[DW-2 -: 8];
        end
        SEED: begin
          x_q    <= RW'(rom_dout) << (RW - 8);
          iter_q <= '0;
        end
        MUL_A: e_q <= e_next;
        MUL_B: begin
          x_q    <= x_next;
          iter_q <= iter_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign recip       = x_q;
  assign shift       = shift_q;
  assign div_by_zero = dbz_q;
  assign rom_addr    = rom_addr_q;

`ifdef RECIP_SEED_NR_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count    <= '0;
      busy_cycles <= '0;
    end else begin
      if (out_valid && out_ready) op_count <= op_count + 16'd1;
      if (state_q != IDLE && busy_cycles != '1) busy_cycles <= busy_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_recip_seed_nr_ctrl.sv
// Testbench for recip_seed_nr_ctrl: scoreboard of expected results computed from
// exact rational arithmetic, compared by a monitor when results are presented.
module tb_recip_seed_nr_ctrl;
  localparam int DW = 16;
  localparam int RW = 16;
  localparam int ITER = 2;
  localparam int SW = $clog2(DW);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] divisor = '0;
  logic [7:0]    rom_addr;
  logic [7:0]    rom_dout;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [RW-1:0] recip;
  logic [SW-1:0] shift;
  logic          div_by_zero;
`ifdef RECIP_SEED_NR_STATS_EN
  logic [15:0]   op_count;
  logic [31:0]   busy_cycles;
`endif

  recip_seed_nr_ctrl #(.DW(DW), .RW(RW), .ITER(ITER)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .divisor(divisor),
    .rom_addr(rom_addr), .rom_dout(rom_dout), .out_valid(out_valid), .out_ready(out_ready),
    .recip(recip), .shift(shift), .div_by_zero(div_by_zero)
`ifdef RECIP_SEED_NR_STATS_EN
    , .op_count(op_count), .busy_cycles(busy_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Seed ROM: 1/(1 + addr/256) in Q0.8, clamped to 0xFF.
  logic [7:0] rom_tab [256];
  assign rom_dout = rom_tab[rom_addr];

  typedef struct {
    int  ideal;
    int  shift;
    bit  dbz;
    int  addr;
    int  tol;
    int  acc;
    int  lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_addr = 0;
  bit   rand_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int d, input int tol);
    exp_t   e;
    int     l;
    longint q;
    e.acc = cyc + 1;
    if (d == 0) begin
      e.ideal = 65535; e.shift = 0; e.dbz = 1'b1; e.addr = last_addr; e.tol = 0; e.lat = 1;
    end else begin
      l = $clog2(d + 1) - 1;
      q = (64'd1 << (RW + l)) / d;
      if (q > 65535) q = 65535;
      e.ideal = int'(q);
      e.shift = l;
      e.dbz   = 1'b0;
      e.addr  = ((d << (DW - 1 - l)) >> 7) & 255;
      e.tol   = tol;
      e.lat   = 3 + 2 * ITER;
      last_addr = e.addr;
    end
    sb_q.push_back(e);
  endtask

  // Called just after a rising edge; returns 1 time unit after the accept edge.
  task automatic issue(input int d, input int tol);
    int n;
    n = 0;
    in_valid = 1'b1;
    divisor  = DW'(d);
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: in_ready never rose for divisor %0d", d);
      in_valid = 1'b0;
    end else begin
      push_exp(d, tol);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      divisor  = DW'($urandom);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding", sb_q.size());
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_recip"}, recip, 0);
    chk({tag, "_shift"}, shift, 0);
    chk({tag, "_dbz"}, div_by_zero, 0);
    chk({tag, "_rom_addr"}, rom_addr, 0);
  endtask

  // Monitor: pops an expectation the first cycle a result is shown, then checks it
  // stays put until accepted and that the block is idle the cycle after acceptance.
  initial begin : monitor
    exp_t          cur;
    bit            seen;
    bit            expect_idle;
    logic [RW-1:0] h_recip;
    logic [SW-1:0] h_shift;
    logic          h_dbz;
    int            diff;
    seen = 1'b0;
    expect_idle = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 1'b0;
        expect_idle = 1'b0;
      end else begin
        if (expect_idle) begin
          chk("idle_after_accept_in_ready", in_ready, 1);
          chk("idle_after_accept_out_valid", out_valid, 0);
          expect_idle = 1'b0;
        end
        if (out_valid) begin
          if (!seen) begin
            if (sb_q.size() == 0) begin
              n_tests++; n_fail++;
              $display("FAIL unexpected_result: recip=%0h with empty scoreboard", recip);
            end else begin
              cur = sb_q.pop_front();
              diff = int'(recip) - cur.ideal;
              if (diff < 0) diff = -diff;
              n_tests++;
              if (diff > cur.tol) begin
                n_fail++;
                $display("FAIL recip: got %0h, expected %0h +/- %0d", recip, cur.ideal, cur.tol);
              end
              chk("shift", shift, cur.shift);
              chk("div_by_zero", div_by_zero, cur.dbz);
              chk("rom_addr", rom_addr, cur.addr);
              chk("latency", cyc - cur.acc + 1, cur.lat);
            end
            h_recip = recip; h_shift = shift; h_dbz = div_by_zero;
            seen = 1'b1;
          end else begin
            chk("hold_recip", recip, h_recip);
            chk("hold_shift", shift, h_shift);
            chk("hold_dbz", div_by_zero, h_dbz);
          end
          chk("busy_in_ready", in_ready, 0);
          if (out_ready) begin
            seen = 1'b0;
            expect_idle = 1'b1;
          end
        end
      end
    end
  end

  initial begin : ready_gen
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin : stim
    int n;
    int b;
    int v;
    for (int a = 0; a < 256; a++) begin
      v = 65536 / (256 + a);
      rom_tab[a] = (v > 255) ? 8'hFF : 8'(v);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("por");
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", in_ready, 1);
    @(posedge clk); #1;

`ifdef RECIP_SEED_NR_STATS_EN
    out_ready = 1'b1;
    issue(1234, 2); issue(77, 2); issue(40000, 2);
    wait_drain();
    chk("op_count_3", op_count, 3);
    chk("busy_cycles_21", busy_cycles, 21);
    @(posedge clk); #1;
    force dut.op_count = 16'hFFFF;
    @(negedge clk);
    release dut.op_count;
    @(posedge clk); #1;
    issue(9, 2);
    wait_drain();
    chk("op_count_wrap", op_count, 0);
    @(posedge clk); #1;
`endif

    // directed: 1, 3 and 0 with immediate acceptance
    out_ready = 1'b1;
    issue(1, 0);
    issue(3, 1);
    issue(0, 0);
    wait_drain();
    @(posedge clk); #1;

    // result held while downstream stalls
    out_ready = 1'b0;
    issue(16'h8000, 0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("stall_out_valid_seen", out_valid, 1);
    repeat (5) @(posedge clk);
    #1; out_ready = 1'b1;
    wait_drain();
    @(posedge clk); #1;

    // reset while the first multiply of a step is in progress
    issue(16'h1234, 2);
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
    sb_q.delete();
    last_addr = 0;
    @(negedge clk);
    check_reset("mid_op_rst");
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("ready_after_mid_rst", in_ready, 1);
    @(posedge clk); #1;
    issue(5, 1);
    wait_drain();
    @(posedge clk); #1;

    // randomized divisors of varied magnitude with random downstream stalls
    rand_rdy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      b = $urandom_range(0, 16);
      if (b == 0) v = 0;
      else begin
        v = int'($urandom & ((32'd1 << b) - 1));
        if ($urandom_range(0, 1) == 1) v = v | (1 << (b - 1));
      end
      issue(v, 2);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    @(posedge clk); #1;
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
